// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: types and helpers shared by the 7-segment scanner.
//   state_e   - per-slot FSM encoding (ST_SHOW lit, ST_GUARD all-off gap)
//   ANODE_OFF - inactive level of one common-anode enable line
//   idx_w     - width of the digit index for a given digit count
//   cnt_w     - width of the slot timer for the given show/guard lengths
package seg_scan_pkg;

  typedef enum logic {ST_SHOW = 1'b0, ST_GUARD = 1'b1} state_e;

  localparam logic ANODE_OFF = 1'b1;

  function automatic int idx_w(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

  function automatic int cnt_w(input int div_cyc, input int guard_cyc);
    int m;
    m = (div_cyc > guard_cyc) ? div_cyc : guard_cyc;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/seg_scan_tick.sv
// seg_scan_tick: slot timer for the scanner.
//   clk, rst_n - clock, async active-low reset
//   in_guard   - 1 while the FSM is in its guard gap, 0 while a digit is lit
//   tick       - end-of-state strobe: last cycle of the current SHOW/GUARD period
// The counter restarts at 0 on every tick so each state starts a fresh count.
module seg_scan_tick import seg_scan_pkg::*; #(
  parameter int DIV_CYC   = 1000,
  parameter int GUARD_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_guard,
  output logic tick
);

  localparam int CW = cnt_w(DIV_CYC, GUARD_CYC);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(DIV_CYC - 1);
  // With no guard the FSM never enters ST_GUARD, so this value is unused.
  localparam logic [CW-1:0] GUARD_LAST = CW'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);

  logic [CW-1:0] div_cnt_q, div_cnt_d;

  always_comb begin
    tick      = in_guard ? (div_cnt_q == GUARD_LAST) : (div_cnt_q == SHOW_LAST);
    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_cnt_q <= '0;
    else        div_cnt_q <= div_cnt_d;
  end

endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed scanner for a common-anode 7-segment bank.
//   in_valid/in_ready/in_data/in_dp_mask - word handshake; nibble i = digit i
//   digit_num  - 4-bit code for the external hex-to-segment decoder
//   an         - anode enables, active-low, one per digit
//   dp         - decimal point, active-low
//   frame_done - 1-cycle pulse after each frame boundary
// One word is buffered in a pending register and copied to the active
// register only when the scan wraps, so a frame never mixes two words.
// Optional: define SEG_SCAN_LZ_BLANK_EN to blank leading-zero digits.
module seg_scan_mux import seg_scan_pkg::*; #(
  parameter int DIGITS    = 8,
  parameter int DIV_CYC   = 1000,
  parameter int GUARD_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_data,
  input  logic [DIGITS-1:0]     in_dp_mask,
  output logic [3:0]            digit_num,
  output logic [DIGITS-1:0]     an,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int IW = idx_w(DIGITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] act_data_q, act_data_d, pend_data_q, pend_data_d;
  logic [DIGITS-1:0]   act_mask_q, act_mask_d, pend_mask_q, pend_mask_d;
  logic                pend_vld_q, pend_vld_d;
  logic [3:0]          digit_num_q, digit_num_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                dp_q, dp_d, frame_done_q, frame_done_d;
  logic                tick, slot_end, wrap, accept;
  logic [DIGITS-1:0]   lz_blank;

  seg_scan_tick #(.DIV_CYC(DIV_CYC), .GUARD_CYC(GUARD_CYC)) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_guard (state_q == ST_GUARD),
    .tick     (tick)
  );

  assign in_ready = ~pend_vld_q;
  assign accept   = in_valid & in_ready;
  // A slot ends after its guard, or straight after SHOW when there is no guard.
  assign slot_end = tick & ((state_q == ST_GUARD) | (GUARD_CYC == 0));
  assign wrap     = slot_end & (idx_q == LAST_IDX);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_SHOW;
    else        state_q <= state_d;
  end

  // Next state, slot index and word buffers
  always_comb begin
    state_d = state_q;
    if (tick) begin
      if (state_q == ST_SHOW) state_d = (GUARD_CYC == 0) ? ST_SHOW : ST_GUARD;
      else                    state_d = ST_SHOW;
    end
    idx_d = idx_q;
    if (slot_end) idx_d = wrap ? '0 : idx_q + 1'b1;

    act_data_d  = act_data_q;
    act_mask_d  = act_mask_q;
    pend_data_d = pend_data_q;
    pend_mask_d = pend_mask_q;
    pend_vld_d  = pend_vld_q;
    // accept and a pending swap are exclusive: accept needs pend_vld_q == 0,
    // so a word taken on the wrap edge stays pending for a full frame.
    if (wrap && pend_vld_q) begin
      act_data_d = pend_data_q;
      act_mask_d = pend_mask_q;
      pend_vld_d = 1'b0;
    end else if (accept) begin
      pend_data_d = in_data;
      pend_mask_d = in_dp_mask;
      pend_vld_d  = 1'b1;
    end
  end

`ifdef SEG_SCAN_LZ_BLANK_EN
  // Digit i (>0) is blank when it and every digit above it are zero.
  always_comb begin
    logic nz_above;
    lz_blank = '0;
    nz_above = 1'b0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      nz_above    = nz_above | (act_data_q[4*i +: 4] != 4'h0);
      lz_blank[i] = ~nz_above;
    end
  end
`else
  assign lz_blank = '0;
`endif

  // Outputs, registered from the current slot
  always_comb begin
    an_d         = {DIGITS{ANODE_OFF}};
    dp_d         = 1'b1;
    digit_num_d  = digit_num_q;
    frame_done_d = wrap;
    if (state_q == ST_SHOW) begin
      digit_num_d = act_data_q[{idx_q, 2'b00} +: 4];
      dp_d        = ~act_mask_q[idx_q];
      if (!lz_blank[idx_q]) an_d[idx_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= '0;
      act_data_q   <= '0;
      act_mask_q   <= '0;
      pend_data_q  <= '0;
      pend_mask_q  <= '0;
      pend_vld_q   <= 1'b0;
      digit_num_q  <= 4'h0;
      an_q         <= {DIGITS{ANODE_OFF}};
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      act_data_q   <= act_data_d;
      act_mask_q   <= act_mask_d;
      pend_data_q  <= pend_data_d;
      pend_mask_q  <= pend_mask_d;
      pend_vld_q   <= pend_vld_d;
      digit_num_q  <= digit_num_d;
      an_q         <= an_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign digit_num  = digit_num_q;
  assign an         = an_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: directed bench for seg_scan_mux with DIGITS=4, DIV_CYC=4,
// GUARD_CYC=1 (20-cycle frame). Inputs change and outputs are sampled on
// the falling edge; the DUT registers on the rising edge.
module tb_seg_scan_mux;

  logic        gclk = 1'b0;
  logic        grst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_dp_mask;
  logic [3:0]  digit_num;
  logic [3:0]  an;
  logic        dp;
  logic        frame_done;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 gclk = ~gclk;

  seg_scan_mux #(.DIGITS(4), .DIV_CYC(4), .GUARD_CYC(1)) dut (
    .clk        (gclk),
    .rst_n      (grst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_dp_mask (in_dp_mask),
    .digit_num  (digit_num),
    .an         (an),
    .dp         (dp),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge gclk);
  endtask

  // Expected anode pattern for digit i of word d.
  function automatic logic [3:0] exp_an(input logic [15:0] d, input int i);
    logic [3:0] a;
    a    = 4'hF;
    a[i] = 1'b0;
`ifdef SEG_SCAN_LZ_BLANK_EN
    if (i > 0 && (d >> (4 * i)) == 16'h0) a = 4'hF;
`endif
    return a;
  endfunction

  // Called at the sample just after a boundary edge; walks one full frame
  // and ends at the sample after the next boundary.
  task automatic check_frame(input logic [15:0] d, input logic [3:0] m);
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 4; k++) begin
        step(1);
        chk("an_show", {12'h0, an}, {12'h0, exp_an(d, i)});
        chk("dig_show", {12'h0, digit_num}, {12'h0, d[4*i +: 4]});
        chk("dp_show", {15'h0, dp}, {15'h0, !m[i]});
        chk("fd_low", {15'h0, frame_done}, 16'h0);
      end
      step(1);
      chk("an_guard", {12'h0, an}, 16'h000F);
      chk("dp_guard", {15'h0, dp}, 16'h0001);
      chk("dig_guard", {12'h0, digit_num}, {12'h0, d[4*i +: 4]});
      chk("fd_guard", {15'h0, frame_done}, {15'h0, i == 3});
    end
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      step(1);
      n++;
    end while (frame_done !== 1'b1 && n < 45);
    chk("frame_seen", {15'h0, frame_done}, 16'h0001);
  endtask

  // First slots after reset release with an empty active word.
  task automatic after_reset_seq();
    logic [3:0] seq [6];
    seq = '{4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1111, 4'b1101};
    for (int k = 0; k < 6; k++) begin
      step(1);
      chk("an_boot", {12'h0, an}, {12'h0, seq[k]});
      chk("dig_boot", {12'h0, digit_num}, 16'h0);
      chk("dp_boot", {15'h0, dp}, 16'h0001);
    end
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] m);
    chk("rdy_load", {15'h0, in_ready}, 16'h0001);
    in_valid   = 1'b1;
    in_data    = d;
    in_dp_mask = m;
    step(1);
    in_valid = 1'b0;
    chk("rdy_taken", {15'h0, in_ready}, 16'h0);
  endtask

  initial begin
    int n;
    grst_n     = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_dp_mask = '0;

    // reset state and first slots
    step(2);
    chk("rst_an", {12'h0, an}, 16'h000F);
    chk("rst_dp", {15'h0, dp}, 16'h0001);
    chk("rst_dig", {12'h0, digit_num}, 16'h0);
    chk("rst_fd", {15'h0, frame_done}, 16'h0);
    chk("rst_rdy", {15'h0, in_ready}, 16'h0001);
    grst_n = 1'b1;
    after_reset_seq();

    // basic word
    load(16'h1234, 4'b0100);
    wait_frame();
    check_frame(16'h1234, 4'b0100);

    // back-to-back words: second one waits for the boundary
    in_valid   = 1'b1;
    in_data    = 16'h5678;
    in_dp_mask = 4'b0001;
    step(1);
    chk("rdy_w1", {15'h0, in_ready}, 16'h0);
    in_data    = 16'h9ABC;
    in_dp_mask = 4'b1000;
    n = 0;
    do begin
      step(1);
      n++;
      if (frame_done !== 1'b1) chk("rdy_hold", {15'h0, in_ready}, 16'h0);
    end while (frame_done !== 1'b1 && n < 30);
    chk("w1_boundary", {15'h0, frame_done}, 16'h0001);
    chk("rdy_free", {15'h0, in_ready}, 16'h0001);
    step(1);
    chk("rdy_w2", {15'h0, in_ready}, 16'h0);
    in_valid = 1'b0;
    chk("w1_an0", {12'h0, an}, 16'h000E);
    chk("w1_dig0", {12'h0, digit_num}, 16'h0008);
    chk("w1_dp0", {15'h0, dp}, 16'h0);
    wait_frame();
    check_frame(16'h9ABC, 4'b1000);

    // word accepted on the boundary edge itself stays pending one frame
    step(19);
    in_valid   = 1'b1;
    in_data    = 16'hABCD;
    in_dp_mask = 4'b0010;
    step(1);
    chk("edge_fd", {15'h0, frame_done}, 16'h0001);
    chk("edge_rdy", {15'h0, in_ready}, 16'h0);
    in_valid = 1'b0;
    check_frame(16'h9ABC, 4'b1000);
    check_frame(16'hABCD, 4'b0010);

    // reset mid-SHOW on digit 2 with a word pending
    load(16'h4321, 4'b1111);
    step(11);
    chk("pre_rst_an", {12'h0, an}, 16'h000B);
    grst_n = 1'b0;
    #1;
    chk("mid_rst_an", {12'h0, an}, 16'h000F);
    chk("mid_rst_dp", {15'h0, dp}, 16'h0001);
    chk("mid_rst_dig", {12'h0, digit_num}, 16'h0);
    chk("mid_rst_rdy", {15'h0, in_ready}, 16'h0001);
    step(2);
    grst_n = 1'b1;
    after_reset_seq();
    wait_frame();
    check_frame(16'h0000, 4'b0000);

    // leading zeros (blanked only when the option is built in)
    load(16'h0050, 4'b0000);
    wait_frame();
    check_frame(16'h0050, 4'b0000);
    load(16'h0000, 4'b0001);
    wait_frame();
    check_frame(16'h0000, 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
